// File: rtl/fetch_request_tracker.sv
// Tracks outstanding instruction-fetch requests in issue order and classifies each
// returning response as accepted, stale (redirected) or erroneous.
module fetch_request_tracker #(
  parameter int ADDRESS_BITS    = 20,
  parameter int MAX_OUTSTANDING = 4,
  parameter int COUNT_BITS      = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    issue_request,
  input  logic [ADDRESS_BITS-1:0] issue_PC,
  input  logic                    fetch_ready,
  output logic                    issue_grant,
  input  logic                    fetch_valid,
  input  logic [ADDRESS_BITS-1:0] fetch_address_in,
  input  logic                    redirect,
  output logic                    response_accept,
  output logic                    flush_fetch_receive,
  output logic                    i_mem_hazard,
  output logic [COUNT_BITS-1:0]   outstanding_count,
  output logic                    protocol_error,
  output logic [31:0]             hazard_cycles
);

  localparam int PTR_BITS = $clog2(MAX_OUTSTANDING);
  localparam logic [COUNT_BITS-1:0] MAX_CNT = COUNT_BITS'(MAX_OUTSTANDING);

  logic [ADDRESS_BITS-1:0]    addr_q [MAX_OUTSTANDING];
  logic [ADDRESS_BITS-1:0]    addr_d [MAX_OUTSTANDING];
  logic [MAX_OUTSTANDING-1:0] stale_q, stale_d;
  logic [MAX_OUTSTANDING-1:0] live_after_pop;
  logic [PTR_BITS-1:0]        head_q, head_d;
  logic [PTR_BITS-1:0]        tail_q, tail_d;
  logic [COUNT_BITS-1:0]      count_q, count_d;
  logic                       protocol_error_q, protocol_error_d;
  logic [31:0]                hazard_cycles_q, hazard_cycles_d;

  logic empty;
  logic pop;
  logic head_stale;
  logic head_match;
  logic bad_resp;

  // Distance of a slot from the head, i.e. its age rank among tracked entries.
  function automatic logic [PTR_BITS-1:0] slot_offset(input int slot,
                                                      input logic [PTR_BITS-1:0] head);
    return PTR_BITS'(slot) - head;
  endfunction

  assign empty      = (count_q == '0);
  assign pop        = fetch_valid & ~empty;
  assign head_stale = stale_q[head_q];
  assign head_match = (addr_q[head_q] == fetch_address_in);

  // A full tracker can still grant when the head retires in the same cycle.
  assign issue_grant         = issue_request & fetch_ready & ((count_q < MAX_CNT) | pop);
  assign response_accept     = pop & ~head_stale & ~redirect & head_match;
  assign flush_fetch_receive = fetch_valid & ~response_accept;
  assign i_mem_hazard        = ~response_accept;
  assign bad_resp            = fetch_valid & (empty | (~head_stale & ~redirect & ~head_match));

  always_comb begin
    live_after_pop = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (({1'b0, slot_offset(i, head_q)} >= COUNT_BITS'(pop)) &&
          ({1'b0, slot_offset(i, head_q)} < count_q)) begin
        live_after_pop[i] = 1'b1;
      end
    end
  end

  always_comb begin
    addr_d           = addr_q;
    stale_d          = stale_q;
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q + COUNT_BITS'(issue_grant) - COUNT_BITS'(pop);
    protocol_error_d = protocol_error_q | bad_resp;
    hazard_cycles_d  = hazard_cycles_q;

    if (redirect) begin
      stale_d = stale_q | live_after_pop;
    end
    if (pop) begin
      head_d = head_q + PTR_BITS'(1);
    end
    // The entry pushed during a redirect is the new target and stays live.
    if (issue_grant) begin
      addr_d[tail_q]  = issue_PC;
      stale_d[tail_q] = 1'b0;
      tail_d          = tail_q + PTR_BITS'(1);
    end
    if (i_mem_hazard & ~empty & ~redirect & (hazard_cycles_q != 32'hFFFF_FFFF)) begin
      hazard_cycles_d = hazard_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        addr_q[i] <= '0;
      end
      stale_q          <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      protocol_error_q <= 1'b0;
      hazard_cycles_q  <= '0;
    end else begin
      addr_q           <= addr_d;
      stale_q          <= stale_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      protocol_error_q <= protocol_error_d;
      hazard_cycles_q  <= hazard_cycles_d;
    end
  end

  assign outstanding_count = count_q;
  assign protocol_error    = protocol_error_q;
  assign hazard_cycles     = hazard_cycles_q;

endmodule

// File: tb/tb_fetch_request_tracker.sv
// Directed bench for fetch_request_tracker: a queue-based reference model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_fetch_request_tracker;

  localparam int AB = 20;
  localparam int MO = 4;
  localparam int CB = 3;

  // Clock/reset and DUT signals
  logic          clock = 1'b0;
  logic          reset;
  logic          issue_request;
  logic [AB-1:0] issue_PC;
  logic          fetch_ready;
  logic          issue_grant;
  logic          fetch_valid;
  logic [AB-1:0] fetch_address_in;
  logic          redirect;
  logic          response_accept;
  logic          flush_fetch_receive;
  logic          i_mem_hazard;
  logic [CB-1:0] outstanding_count;
  logic          protocol_error;
  logic [31:0]   hazard_cycles;

  always #5 clock = ~clock;

  fetch_request_tracker #(
    .ADDRESS_BITS(AB),
    .MAX_OUTSTANDING(MO),
    .COUNT_BITS(CB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .issue_request(issue_request),
    .issue_PC(issue_PC),
    .fetch_ready(fetch_ready),
    .issue_grant(issue_grant),
    .fetch_valid(fetch_valid),
    .fetch_address_in(fetch_address_in),
    .redirect(redirect),
    .response_accept(response_accept),
    .flush_fetch_receive(flush_fetch_receive),
    .i_mem_hazard(i_mem_hazard),
    .outstanding_count(outstanding_count),
    .protocol_error(protocol_error),
    .hazard_cycles(hazard_cycles)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-order list of outstanding requests
  typedef struct packed {
    logic [AB-1:0] addr;
    logic          stale;
  } ent_t;

  ent_t        mq[$];
  logic        err_m = 1'b0;
  logic [31:0] haz_m = '0;

  task automatic predict(output logic g, output logic acc, output logic fl,
                         output logic bad, output logic pop);
    pop = fetch_valid && (mq.size() != 0);
    g   = issue_request && fetch_ready && ((mq.size() < MO) || pop);
    acc = 1'b0;
    fl  = 1'b0;
    bad = 1'b0;
    if (fetch_valid) begin
      if (mq.size() == 0) begin
        fl  = 1'b1;
        bad = 1'b1;
      end else if (mq[0].stale || redirect) begin
        fl = 1'b1;
      end else if (mq[0].addr != fetch_address_in) begin
        fl  = 1'b1;
        bad = 1'b1;
      end else begin
        acc = 1'b1;
      end
    end
  endtask

  always @(posedge clock or posedge reset) begin : model_update
    logic g, acc, fl, bad, pop;
    ent_t e;
    if (reset) begin
      mq.delete();
      err_m = 1'b0;
      haz_m = '0;
    end else begin
      predict(g, acc, fl, bad, pop);
      if (!acc && (mq.size() != 0) && !redirect && (haz_m != 32'hFFFF_FFFF)) haz_m = haz_m + 32'd1;
      if (bad) err_m = 1'b1;
      if (pop) void'(mq.pop_front());
      if (redirect) begin
        foreach (mq[i]) mq[i].stale = 1'b1;
      end
      if (g) begin
        e.addr  = issue_PC;
        e.stale = 1'b0;
        mq.push_back(e);
      end
    end
  end

  // Scoreboard compare: every cycle, just before the rising edge
  always begin : compare
    logic g, acc, fl, bad, pop;
    @(negedge clock);
    #4;
    predict(g, acc, fl, bad, pop);
    chk("issue_grant", {31'd0, issue_grant}, {31'd0, g});
    chk("response_accept", {31'd0, response_accept}, {31'd0, acc});
    chk("flush_fetch_receive", {31'd0, flush_fetch_receive}, {31'd0, fl});
    chk("i_mem_hazard", {31'd0, i_mem_hazard}, {31'd0, !acc});
    chk("outstanding_count", {29'd0, outstanding_count}, 32'(mq.size()));
    chk("protocol_error", {31'd0, protocol_error}, {31'd0, err_m});
    chk("hazard_cycles", hazard_cycles, haz_m);
  end

  // Driver tasks: inputs change on the falling edge, held for one cycle
  task automatic step(input logic ir, input logic [AB-1:0] pc, input logic fr,
                      input logic fv, input logic [AB-1:0] tag, input logic rd);
    @(negedge clock);
    issue_request    = ir;
    issue_PC         = pc;
    fetch_ready      = fr;
    fetch_valid      = fv;
    fetch_address_in = tag;
    redirect         = rd;
    #4;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    issue_request = 1'b0;
    fetch_valid   = 1'b0;
    redirect      = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    issue_request    = 1'b0;
    issue_PC         = '0;
    fetch_ready      = 1'b1;
    fetch_valid      = 1'b0;
    fetch_address_in = '0;
    redirect         = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    idle();
    chk("rst_hazard", {31'd0, i_mem_hazard}, 32'd1);
    chk("rst_count", {29'd0, outstanding_count}, 32'd0);
    chk("rst_flush", {31'd0, flush_fetch_receive}, 32'd0);

    // Three in-order fetches, responses two cycles behind
    step(1'b1, 20'h100, 1'b1, 1'b0, '0, 1'b0);
    chk("t1_grant0", {31'd0, issue_grant}, 32'd1);
    step(1'b1, 20'h104, 1'b1, 1'b0, '0, 1'b0);
    chk("t1_count1", {29'd0, outstanding_count}, 32'd1);
    step(1'b1, 20'h108, 1'b1, 1'b1, 20'h100, 1'b0);
    chk("t1_accept0", {31'd0, response_accept}, 32'd1);
    chk("t1_count2", {29'd0, outstanding_count}, 32'd2);
    step(1'b0, '0, 1'b1, 1'b1, 20'h104, 1'b0);
    chk("t1_accept1", {31'd0, response_accept}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 20'h108, 1'b0);
    chk("t1_accept2", {31'd0, response_accept}, 32'd1);
    chk("t1_count_last", {29'd0, outstanding_count}, 32'd1);
    step(1'b1, 20'h10C, 1'b0, 1'b0, '0, 1'b0);
    chk("t1_no_ready_grant", {31'd0, issue_grant}, 32'd0);
    chk("t1_count_end", {29'd0, outstanding_count}, 32'd0);
    chk("t1_err", {31'd0, protocol_error}, 32'd0);

    // Fill the tracker, then push and pop in the same cycle while full
    for (int k = 0; k < 5; k++) step(1'b1, 20'h400 + 20'(4 * k), 1'b1, 1'b0, '0, 1'b0);
    chk("t2_full_grant", {31'd0, issue_grant}, 32'd0);
    chk("t2_full_count", {29'd0, outstanding_count}, 32'd4);
    step(1'b1, 20'h414, 1'b1, 1'b1, 20'h400, 1'b0);
    chk("t2_full_pushpop_grant", {31'd0, issue_grant}, 32'd1);
    chk("t2_full_pushpop_accept", {31'd0, response_accept}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 20'h404, 1'b0);
    chk("t2_count_after_pushpop", {29'd0, outstanding_count}, 32'd4);
    step(1'b0, '0, 1'b1, 1'b1, 20'h408, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 20'h40C, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 20'h414, 1'b0);
    chk("t2_wrapped_accept", {31'd0, response_accept}, 32'd1);
    idle();
    chk("t2_count_end", {29'd0, outstanding_count}, 32'd0);

    // Redirect while the new target is granted
    step(1'b1, 20'h200, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 20'h204, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 20'h300, 1'b1, 1'b0, '0, 1'b1);
    chk("t3_redirect_grant", {31'd0, issue_grant}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 20'h200, 1'b0);
    chk("t3_stale0_flush", {31'd0, flush_fetch_receive}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 20'h204, 1'b0);
    chk("t3_stale1_flush", {31'd0, flush_fetch_receive}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b1, 20'h300, 1'b0);
    chk("t3_target_accept", {31'd0, response_accept}, 32'd1);
    // Redirect in the response cycle overrides a matching head
    step(1'b1, 20'h600, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 20'h600, 1'b1);
    chk("t3_redirect_override", {31'd0, flush_fetch_receive}, 32'd1);
    idle();
    chk("t3_count_end", {29'd0, outstanding_count}, 32'd0);
    chk("t3_err", {31'd0, protocol_error}, 32'd0);

    // Tag mismatch sets the sticky error
    step(1'b1, 20'h200, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 20'h210, 1'b0);
    chk("t4_mismatch_flush", {31'd0, flush_fetch_receive}, 32'd1);
    chk("t4_mismatch_accept", {31'd0, response_accept}, 32'd0);
    idle();
    chk("t4_count", {29'd0, outstanding_count}, 32'd0);
    repeat (3) idle();
    chk("t4_err_sticky", {31'd0, protocol_error}, 32'd1);

    do_reset();
    idle();
    chk("rst2_err", {31'd0, protocol_error}, 32'd0);

    // Response with nothing outstanding
    step(1'b0, '0, 1'b1, 1'b1, 20'h050, 1'b0);
    chk("t5_empty_flush", {31'd0, flush_fetch_receive}, 32'd1);
    idle();
    chk("t5_count", {29'd0, outstanding_count}, 32'd0);
    chk("t5_err", {31'd0, protocol_error}, 32'd1);

    // Stall counting, then asynchronous reset mid-wait
    step(1'b1, 20'h500, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 20'h504, 1'b1, 1'b0, '0, 1'b0);
    repeat (10) idle();
    chk("t6_hazard", hazard_cycles, 32'd10);
    chk("t6_count", {29'd0, outstanding_count}, 32'd2);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_count", {29'd0, outstanding_count}, 32'd0);
    chk("t6_async_hazard", hazard_cycles, 32'd0);
    chk("t6_async_err", {31'd0, protocol_error}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
